cordic_quadrant_wrap: RTL

//  Full-circle front/back end for cordic_pipeline, which only handles first-quadrant angles.

---
 rtl/cordic_quadrant_wrap.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cordic_quadrant_wrap.sv
// Full-circle wrapper around a first-quadrant CORDIC core.
// The phase is split into a quadrant and a 90-degree residual; the residual
// drives the core as 8.8 degrees. The quadrant travels alongside the core
// through a tag line, and the core results are then swapped/negated to give
// sine and cosine over the whole circle.
module cordic_quadrant_wrap #(
    parameter int WIDTH    = 16,
    parameter int CORE_LAT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] phase_in,
    output logic [WIDTH-1:0] core_angle,
    input  logic [WIDTH-1:0] core_sine,
    input  logic [WIDTH-1:0] core_cosine,
    output logic             out_valid,
    output logic [WIDTH-1:0] sine,
    output logic [WIDTH-1:0] cosine,
    output logic [1:0]       out_quad
);

    // Residual is a fraction of 90 deg; times 45 then >>5 gives 8.8 degrees
    // (x * 90 * 256 / 2^14 == x * 45 / 32).
    localparam int FRAC_W = WIDTH - 2;
    localparam int PROD_W = FRAC_W + 6;

    // Two's complement negate; the core never exceeds |1.0| so this cannot
    // overflow, and -0 naturally stays 0.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return WIDTH'(~v + 1'b1);
    endfunction

    // S1 state
    logic              vld1_q, vld1_d;
    logic [1:0]        q1_q, q1_d;
    logic [PROD_W-1:0] prod_q, prod_d;

    // S2 state (core_angle plus the tag entry point)
    logic [WIDTH-1:0]  core_angle_q, core_angle_d;
    logic              vld2_q, vld2_d;
    logic [1:0]        q2_q, q2_d;

    // Tag delay line matched to the core latency
    logic [CORE_LAT-1:0] tag_vld_q, tag_vld_d;
    logic [1:0]          tag_quad_q [CORE_LAT];
    logic [1:0]          tag_quad_d [CORE_LAT];

    // S3 output register
    logic              out_valid_q, out_valid_d;
    logic [1:0]        out_quad_q, out_quad_d;
    logic [WIDTH-1:0]  sine_q, sine_d;
    logic [WIDTH-1:0]  cosine_q, cosine_d;

    logic              t_vld;
    logic [1:0]        t_quad;
    logic              prod_lsb_unused;

    assign t_vld           = tag_vld_q[CORE_LAT-1];
    assign t_quad          = tag_quad_q[CORE_LAT-1];
    assign prod_lsb_unused = ^prod_q[4:0];

    // S1: capture quadrant and scale the residual; hold on bubbles
    always_comb begin
        vld1_d = in_valid;
        q1_d   = q1_q;
        prod_d = prod_q;
        if (in_valid) begin
            q1_d   = phase_in[WIDTH-1:WIDTH-2];
            prod_d = PROD_W'(phase_in[FRAC_W-1:0]) * PROD_W'(45);
        end
    end

    // S2: truncate to 8.8 degrees for the core; angle only moves on valid data
    always_comb begin
        vld2_d       = vld1_q;
        q2_d         = q1_q;
        core_angle_d = core_angle_q;
        if (vld1_q) begin
            core_angle_d = {1'b0, prod_q[PROD_W-1:5]};
        end
    end

    // Tag line: shifts every cycle so bubbles keep their relative slot
    always_comb begin
        tag_vld_d     = {tag_vld_q[CORE_LAT-2:0], vld2_q};
        tag_quad_d[0] = q2_q;
        for (int i = 1; i < CORE_LAT; i++) begin
            tag_quad_d[i] = tag_quad_q[i-1];
        end
    end

    // S3: map first-quadrant core results onto the tagged quadrant
    always_comb begin
        out_valid_d = t_vld;
        out_quad_d  = t_quad;
        sine_d      = core_sine;
        cosine_d    = core_cosine;
        case (t_quad)
            2'd0: begin
                sine_d   = core_sine;
                cosine_d = core_cosine;
            end
            2'd1: begin
                sine_d   = core_cosine;
                cosine_d = negate(core_sine);
            end
            2'd2: begin
                sine_d   = negate(core_sine);
                cosine_d = negate(core_cosine);
            end
            default: begin
                sine_d   = negate(core_cosine);
                cosine_d = core_sine;
            end
        endcase
    end

    // All pipeline state with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld1_q       <= 1'b0;
            q1_q         <= '0;
            prod_q       <= '0;
            vld2_q       <= 1'b0;
            q2_q         <= '0;
            core_angle_q <= '0;
            tag_vld_q    <= '0;
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_quad_q[i] <= '0;
            end
            out_valid_q  <= 1'b0;
            out_quad_q   <= '0;
            sine_q       <= '0;
            cosine_q     <= '0;
        end else begin
            vld1_q       <= vld1_d;
            q1_q         <= q1_d;
            prod_q       <= prod_d;
            vld2_q       <= vld2_d;
            q2_q         <= q2_d;
            core_angle_q <= core_angle_d;
            tag_vld_q    <= tag_vld_d;
            for (int i = 0; i < CORE_LAT; i++) begin
                tag_quad_q[i] <= tag_quad_d[i];
            end
            out_valid_q  <= out_valid_d;
            out_quad_q   <= out_quad_d;
            sine_q       <= sine_d;
            cosine_q     <= cosine_d;
        end
    end

    assign core_angle = core_angle_q;
    assign out_valid  = out_valid_q;
    assign out_quad   = out_quad_q;
    assign sine       = sine_q;
    assign cosine     = cosine_q;

endmodule
